// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx datapath between NUM_REQ byte
// producers, tracking each frame through Tx_Active and flagging a dead datapath.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ACT_TIMEOUT = 16,
  parameter int unsigned GAP_CLKS    = 0,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [NUM_REQ-1:0]     Req_Valid,
  input  logic [8*NUM_REQ-1:0]   Req_Byte,
  output logic [NUM_REQ-1:0]     Req_Ready,
  output logic                   Tx_Start,
  output logic [7:0]             Tx_Byte,
  input  logic                   Tx_Active,
  output logic                   Frame_Done,
  output logic [IDX_W-1:0]       Done_Id,
  output logic                   Busy,
  output logic                   Err_Timeout,
  input  logic                   Err_Clr
);

  localparam int unsigned CNT_MAX = (ACT_TIMEOUT > GAP_CLKS) ? ACT_TIMEOUT : GAP_CLKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACT = 2'd1,
    S_BUSY     = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  localparam state_t S_AFTER = (GAP_CLKS == 0) ? S_IDLE : S_GAP;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]   r_id, w_id_nxt;
  logic [NUM_REQ-1:0] r_ready, w_ready_nxt;
  logic               r_start, w_start_nxt;
  logic [7:0]         r_byte, w_byte_nxt;
  logic               r_done, w_done_nxt;
  logic               r_busy;
  logic               r_err, w_err_set;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic [7:0]         w_win_byte;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                              input int unsigned off);
    return IDX_W'((32'(base) + off) % NUM_REQ);
  endfunction

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && Req_Valid[rr_idx(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = rr_idx(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_win_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDX_W'(i)) w_win_byte = Req_Byte[8*i +: 8];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_id_nxt    = r_id;
    w_byte_nxt  = r_byte;
    w_ready_nxt = '0;
    w_start_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // uart_tx has no reset, so never start while it may still be mid-frame.
        if (w_found && !Tx_Active) begin
          w_ready_nxt = NUM_REQ'(1) << w_win;
          w_start_nxt = 1'b1;
          w_byte_nxt  = w_win_byte;
          w_id_nxt    = w_win;
          w_ptr_nxt   = w_win;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_ACT;
        end
      end
      S_WAIT_ACT: begin
        if (Tx_Active) begin
          w_state_nxt = S_BUSY;
        end else if (r_cnt == CNT_W'(ACT_TIMEOUT - 1)) begin
          w_err_set   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_AFTER;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_BUSY: begin
        if (!Tx_Active) begin
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_AFTER;
        end
      end
      S_GAP: begin
        if (r_cnt == CNT_W'(GAP_CLKS)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      r_id    <= '0;
      r_ready <= '0;
      r_start <= 1'b0;
      r_byte  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_id    <= w_id_nxt;
      r_ready <= w_ready_nxt;
      r_start <= w_start_nxt;
      r_byte  <= w_byte_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_err   <= w_err_set | (r_err & ~Err_Clr);
    end
  end

  assign Req_Ready   = r_ready;
  assign Tx_Start    = r_start;
  assign Tx_Byte     = r_byte;
  assign Frame_Done  = r_done;
  assign Done_Id     = r_id;
  assign Busy        = r_busy;
  assign Err_Timeout = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx model (4 clocks per bit).
module tb_uart_tx_arbiter;

  localparam int CPB = 4;

  logic        Clk;
  logic        Rst_n;
  logic [3:0]  Req_Valid;
  logic [31:0] Req_Byte;
  logic [3:0]  Req_Ready;
  logic        Tx_Start;
  logic [7:0]  Tx_Byte;
  logic        Tx_Active;
  logic        Frame_Done;
  logic [1:0]  Done_Id;
  logic        Busy;
  logic        Err_Timeout;
  logic        Err_Clr;

  uart_tx_arbiter #(
    .NUM_REQ    (4),
    .ACT_TIMEOUT(16),
    .GAP_CLKS   (4)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Req_Valid  (Req_Valid),
    .Req_Byte   (Req_Byte),
    .Req_Ready  (Req_Ready),
    .Tx_Start   (Tx_Start),
    .Tx_Byte    (Tx_Byte),
    .Tx_Active  (Tx_Active),
    .Frame_Done (Frame_Done),
    .Done_Id    (Done_Id),
    .Busy       (Busy),
    .Err_Timeout(Err_Timeout),
    .Err_Clr    (Err_Clr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model drives at +1 after the edge, main sequence samples at +2, monitor at +3.
  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  // uart_tx model: no reset, start bit, 8 data bits LSB-first, stop bit.
  logic       uart_en = 1'b1;
  logic       ser;
  logic [7:0] rx_byte;
  int         cur_bit = 99;
  int         fall_cyc = 0;

  initial begin
    Tx_Active = 1'b0;
    ser       = 1'b1;
    rx_byte   = '0;
    forever begin
      @(posedge Clk);
      #1;
      if (uart_en && Tx_Start) begin
        Tx_Active = 1'b1;
        for (int b = 0; b < 10; b++) begin
          cur_bit = b;
          if (b == 0) ser = 1'b0;
          else if (b == 9) ser = 1'b1;
          else begin
            ser = Tx_Byte[b-1];
            rx_byte[b-1] = ser;
          end
          repeat (CPB) begin
            @(posedge Clk);
            #1;
          end
        end
        Tx_Active = 1'b0;
        cur_bit   = 99;
        fall_cyc  = cyc;
      end
    end
  end

  // Protocol monitor: one-hot Ready, Ready only with Tx_Start, Tx_Byte moves only on grants.
  int         viol = 0;
  int         n_start = 0;
  int         n_fd = 0;
  logic [7:0] prev_byte = '0;
  logic       prev_rst = 1'b0;

  initial begin
    forever begin
      @(posedge Clk);
      #3;
      if ($countones(Req_Ready) > 1) viol++;
      if ((Req_Ready != 4'b0) != Tx_Start) viol++;
      if (Rst_n && prev_rst && !Tx_Start && Tx_Byte !== prev_byte) viol++;
      if (Tx_Start) n_start++;
      if (Frame_Done) n_fd++;
      prev_byte = Tx_Byte;
      prev_rst  = Rst_n;
    end
  end

  task automatic wait_start(input string nm);
    int n = 0;
    while (Tx_Start !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({nm, "_start_seen"}, 32'(Tx_Start), 32'd1);
  endtask

  task automatic wait_fd(input string nm);
    int n = 0;
    while (Frame_Done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({nm, "_fd_seen"}, 32'(Frame_Done), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (Busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk({nm, "_idle_seen"}, 32'(Busy), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] bytes;
    logic [1:0]  exp_id;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    int last_fd;
    int snap;
    int n;

    tbl[0]  = '{4'b1111, 32'h43322110, 2'd0, 8'h10};
    tbl[1]  = '{4'b1111, 32'h43322110, 2'd1, 8'h21};
    tbl[2]  = '{4'b1111, 32'h43322110, 2'd2, 8'h32};
    tbl[3]  = '{4'b1111, 32'h43322110, 2'd3, 8'h43};
    tbl[4]  = '{4'b1111, 32'h43322110, 2'd0, 8'h10};
    tbl[5]  = '{4'b1111, 32'h43322110, 2'd1, 8'h21};
    tbl[6]  = '{4'b1111, 32'h43322110, 2'd2, 8'h32};
    tbl[7]  = '{4'b1111, 32'h43322110, 2'd3, 8'h43};
    tbl[8]  = '{4'b0110, 32'h43322110, 2'd1, 8'h21};
    tbl[9]  = '{4'b0110, 32'h43322110, 2'd2, 8'h32};
    tbl[10] = '{4'b1001, 32'h43322110, 2'd3, 8'h43};
    tbl[11] = '{4'b1001, 32'h43322110, 2'd0, 8'h10};
    tbl[12] = '{4'b0001, 32'h433221A5, 2'd0, 8'hA5};
    tbl[13] = '{4'b1000, 32'h43322110, 2'd3, 8'h43};
    tbl[14] = '{4'b0011, 32'h43322110, 2'd0, 8'h10};
    tbl[15] = '{4'b0100, 32'h43322110, 2'd2, 8'h32};

    Rst_n     = 1'b0;
    Req_Valid = '0;
    Req_Byte  = '0;
    Err_Clr   = 1'b0;
    step();
    step();
    chk("reset_outputs", 32'({Req_Ready, Tx_Start, Tx_Byte, Frame_Done, Done_Id, Busy, Err_Timeout}), 32'd0);
    Rst_n = 1'b1;
    step();
    step();

    // Single request, one-cycle latency and pulses.
    Req_Byte  = 32'h433221A5;
    Req_Valid = 4'b0001;
    step();
    chk("t1_start_latency", 32'(Tx_Start), 32'd1);
    chk("t1_ready", 32'(Req_Ready), 32'h1);
    chk("t1_byte", 32'(Tx_Byte), 32'hA5);
    chk("t1_id", 32'(Done_Id), 32'd0);
    chk("t1_busy", 32'(Busy), 32'd1);
    Req_Valid = '0;
    step();
    chk("t1_pulse_end", 32'({Req_Ready, Tx_Start}), 32'd0);
    wait_fd("t1");
    chk("t1_fd_id", 32'(Done_Id), 32'd0);
    chk("t1_fd_latency", 32'(cyc - fall_cyc), 32'd1);
    chk("t1_serial", 32'(rx_byte), 32'hA5);
    chk("t1_fd_busy", 32'(Busy), 32'd1);

    // Inter-frame gap: four busy idle cycles, then the grant cycle.
    Req_Byte  = 32'h43322110;
    Req_Valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_gap_busy", 32'(Busy), (k < 4) ? 32'd1 : 32'd0);
      chk("t3_gap_nostart", 32'(Tx_Start), 32'd0);
    end
    step();
    chk("t3_start", 32'(Tx_Start), 32'd1);
    chk("t3_ready", 32'(Req_Ready), 32'h4);
    chk("t3_byte", 32'(Tx_Byte), 32'h32);
    Req_Valid = '0;
    wait_fd("t3");
    chk("t3_fd_id", 32'(Done_Id), 32'd2);
    wait_idle("t3");

    // Fresh pointer, then table of grant vectors.
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    step();
    last_fd = 0;
    for (int i = 0; i < 16; i++) begin
      Req_Valid = tbl[i].valid;
      Req_Byte  = tbl[i].bytes;
      wait_start("tbl");
      chk($sformatf("tbl%0d_ready", i), 32'(Req_Ready), 32'(4'b0001 << tbl[i].exp_id));
      chk($sformatf("tbl%0d_byte", i), 32'(Tx_Byte), 32'(tbl[i].exp_byte));
      chk($sformatf("tbl%0d_id", i), 32'(Done_Id), 32'(tbl[i].exp_id));
      if (i > 0) chk($sformatf("tbl%0d_gap", i), 32'(cyc - last_fd), 32'd6);
      if (i < 15) begin
        Req_Valid = tbl[i+1].valid;
        Req_Byte  = tbl[i+1].bytes;
      end else begin
        Req_Valid = '0;
      end
      wait_fd("tbl");
      last_fd = cyc;
      chk($sformatf("tbl%0d_fd_id", i), 32'(Done_Id), 32'(tbl[i].exp_id));
      chk($sformatf("tbl%0d_serial", i), 32'(rx_byte), 32'(tbl[i].exp_byte));
    end
    wait_idle("tbl");

    // Requester 1 raises Valid for one cycle while requester 0 is being served.
    Req_Valid = 4'b0001;
    wait_start("t5");
    chk("t5_id", 32'(Done_Id), 32'd0);
    Req_Valid = '0;
    n = 0;
    while (Tx_Active !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("t5_active_seen", 32'(Tx_Active), 32'd1);
    repeat (3) step();
    snap = n_start;
    Req_Valid = 4'b0010;
    step();
    Req_Valid = '0;
    wait_fd("t5");
    wait_idle("t5");
    repeat (10) step();
    chk("t5_no_extra_start", 32'(n_start - snap), 32'd0);

    // Datapath never goes active.
    uart_en   = 1'b0;
    snap      = n_fd;
    Req_Valid = 4'b0010;
    wait_start("t4a");
    s = cyc;
    Req_Valid = '0;
    n = 0;
    while (Err_Timeout !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("t4_err_set", 32'(Err_Timeout), 32'd1);
    chk("t4_err_delay", 32'(cyc - s), 32'd16);
    wait_idle("t4a");
    chk("t4_no_fd", 32'(n_fd - snap), 32'd0);
    chk("t4_err_sticky", 32'(Err_Timeout), 32'd1);
    Err_Clr = 1'b1;
    step();
    Err_Clr = 1'b0;
    chk("t4_err_cleared", 32'(Err_Timeout), 32'd0);
    Req_Valid = 4'b0010;
    wait_start("t4b");
    Req_Valid = '0;
    repeat (15) step();
    chk("t4_err_not_yet", 32'(Err_Timeout), 32'd0);
    Err_Clr = 1'b1;
    step();
    chk("t4_set_wins", 32'(Err_Timeout), 32'd1);
    Err_Clr = 1'b0;
    step();
    chk("t4_set_held", 32'(Err_Timeout), 32'd1);
    Err_Clr = 1'b1;
    step();
    Err_Clr = 1'b0;
    wait_idle("t4b");
    uart_en = 1'b1;

    // Reset during data bit 3, release while the datapath is still active.
    Req_Valid = 4'b0001;
    wait_start("t6");
    chk("t6_first_id", 32'(Done_Id), 32'd0);
    Req_Valid = '0;
    n = 0;
    while (cur_bit != 4 && n < 100) begin
      step();
      n++;
    end
    chk("t6_bit3_reached", 32'(cur_bit), 32'd4);
    Rst_n     = 1'b0;
    Req_Valid = 4'b1000;
    #1;
    chk("t6_reset_async", 32'({Req_Ready, Tx_Start, Tx_Byte, Frame_Done, Done_Id, Busy, Err_Timeout}), 32'd0);
    repeat (3) step();
    chk("t6_reset_held", 32'({Req_Ready, Tx_Start, Tx_Byte, Frame_Done, Done_Id, Busy, Err_Timeout}), 32'd0);
    chk("t6_active_at_release", 32'(Tx_Active), 32'd1);
    Rst_n = 1'b1;
    snap  = n_start;
    n = 0;
    while (Tx_Active === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("t6_active_fell", 32'(Tx_Active), 32'd0);
    chk("t6_no_start_while_active", 32'(n_start - snap), 32'd0);
    chk("t6_no_start_at_fall", 32'(Tx_Start), 32'd0);
    step();
    chk("t6_start_after_fall", 32'(Tx_Start), 32'd1);
    chk("t6_start_cycle", 32'(cyc - fall_cyc), 32'd1);
    chk("t6_ready", 32'(Req_Ready), 32'h8);
    chk("t6_id", 32'(Done_Id), 32'd3);
    Req_Valid = '0;
    wait_fd("t6");
    chk("t6_serial", 32'(rx_byte), 32'h43);
    wait_idle("t6");
    step();

    chk("monitor_violations", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one uart_tx datapath between NUM_REQ byte producers. It accepts a byte from one requester via a valid/ready handshake and pulses Tx_Start with the byte. It then tracks the datapath through Tx_Active and reports completion per requester. It also enforces an optional inter-frame idle gap and flags a datapath that never goes active.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ACT_TIMEOUT, 16, max cycles after Tx_Start to see Tx_Active=1 before flagging error (>=2)
GAP_CLKS, 0, idle cycles inserted after each frame before next grant (0 = none)
IDX_W, $clog2(NUM_REQ), derived localparam, width of requester index

Ports:
Clk  in  1  system clock, all logic on rising edge
Rst_n  in  1  asynchronous active-low reset
Req_Valid  in  NUM_REQ  per-requester byte-available; held with byte until accepted or withdrawn
Req_Byte  in  8*NUM_REQ  packed bytes, requester i at [8*i+7:8*i]
Req_Ready  out  NUM_REQ  one-cycle one-hot pulse: byte of requester i accepted this cycle
Tx_Start  out  1  one-cycle start pulse to uart_tx
Tx_Byte  out  8  byte to uart_tx; stable from Tx_Start until frame completes
Tx_Active  in  1  datapath busy, from uart_tx
Frame_Done  out  1  one-cycle pulse when granted frame finished (Tx_Active fell)
Done_Id  out  IDX_W  requester index of current/last grant; valid with Frame_Done
Busy  out  1  high in every state except IDLE
Err_Timeout  out  1  sticky: Tx_Active not seen within ACT_TIMEOUT
Err_Clr  in  1  clears Err_Timeout

Behaviour:
- Reset (async assert, sync release): state IDLE; Req_Ready=0, Tx_Start=0, Tx_Byte=0, Frame_Done=0, Done_Id=0, Busy=0, Err_Timeout=0; counters 0; RR pointer=NUM_REQ-1, so requester 0 has top priority.
- All outputs registered. Arbitration only on Req_Valid sampled in IDLE; a requester dropping Valid before its Ready pulse is legal and not granted.
- IDLE: grant only if |Req_Valid && Tx_Active==0. Tx_Active==0 is required because uart_tx has no reset and may still be mid-frame after controller reset. Winner g = first valid index searching ptr+1, ptr+2, ... with wrap mod NUM_REQ. On the grant edge: Req_Ready[g]<=1, Tx_Start<=1, Tx_Byte<=Req_Byte[g], Done_Id<=g, ptr<=g, Busy<=1; go WAIT_ACT. Latency: Valid sampled at edge n -> Ready/Tx_Start high for the cycle after edge n.
- WAIT_ACT: Req_Ready and Tx_Start are back to 0 after one cycle. The counter increments each cycle. If Tx_Active==1, go BUSY. If the counter reaches ACT_TIMEOUT-1 without Tx_Active: set Err_Timeout, skip Frame_Done, go GAP (or IDLE if GAP_CLKS==0). The pointer stays advanced.
- BUSY: wait for Tx_Active==0, then pulse Frame_Done for one cycle and go GAP (GAP_CLKS>0) or IDLE.
- GAP: count GAP_CLKS cycles, then IDLE. No grants are issued during GAP.
- Err_Clr clears Err_Timeout. If a timeout set coincides with Err_Clr, the set wins.
- Req_Ready and Tx_Start are never asserted outside the IDLE->WAIT_ACT transition. At most one Req_Ready bit is high in any cycle.
- Tx_Byte changes only on a grant edge.
- Illegal state encoding -> IDLE on next edge, outputs per IDLE.
- Reset mid-frame: outputs drop immediately. After release, no grant occurs until Tx_Active==0.

Test Plan:
1. Single request: uart_tx CLKS_PER_BIT=4, Req_Valid=4'b0001, byte 0xA5 -> Req_Ready[0] and Tx_Start one cycle each, Tx_Byte=0xA5, serial line shows 0xA5 LSB-first. Frame_Done with Done_Id=0 follows one cycle after Tx_Active falls.
2. Round-robin fairness: all four Valid held high, bytes 0x10/0x21/0x32/0x43, 8 frames -> grant order 0,1,2,3,0,1,2,3, each frame's Tx_Byte matches the granted requester's byte, never two Ready bits high.
3. Gap enforcement: GAP_CLKS=4, Valid[2] held high -> exactly 4 idle cycles (Busy=1, no Tx_Start) between Frame_Done and the next Tx_Start, plus the grant cycle.
4. Timeout: Tx_Active tied 0, ACT_TIMEOUT=16 -> Err_Timeout set 16 cycles after Tx_Start, no Frame_Done, returns to IDLE. An Err_Clr pulse clears it; Err_Clr on the same cycle as a new timeout leaves it set.
5. Withdrawn request: Valid[1] high for 1 cycle while controller is BUSY serving requester 0 -> requester 1 never granted, no extra Tx_Start.
6. Reset mid-frame: assert Rst_n low during data bit 3, release while Tx_Active=1 with Valid[3]=1 -> all outputs 0 during reset. First Tx_Start occurs only after Tx_Active falls, and requester 3 is granted (pointer reset to NUM_REQ-1).
